// File: rtl/stream_frame_gen.sv
// Frame traffic source: emits one keep-qualified, multi-lane frame of len_i lanes
// per start command, lane data counting up from seed_i, with full ready backpressure.

module stream_frame_lane #(
    parameter int T_DATA_WIDTH = 4,
    parameter int CW           = 11,
    parameter int LANE         = 0
) (
    input  logic                    active_i,
    input  logic [T_DATA_WIDTH-1:0] base_i,
    input  logic [CW-1:0]           lanes_left_i,
    output logic                    keep_o,
    output logic [T_DATA_WIDTH-1:0] data_o
);
    assign keep_o = active_i && (lanes_left_i > CW'(LANE));
    assign data_o = keep_o ? base_i + T_DATA_WIDTH'(LANE) : '0;
endmodule

module stream_frame_gen #(
    parameter int KEEP_WIDTH   = 3,
    parameter int T_DATA_WIDTH = 4,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    input  logic [T_DATA_WIDTH-1:0] seed_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    m_last_o,
    output logic [KEEP_WIDTH-1:0]   m_keep_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [KEEP_WIDTH]
);
    // Wide enough to hold beat*KEEP_WIDTH for the largest frame without overflow.
    localparam int CW = LEN_WIDTH + $clog2(KEEP_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat_q;
    logic [T_DATA_WIDTH-1:0] seed_q;

    logic                    accept;
    logic                    sending;
    logic                    hs;
    logic                    last_beat;
    logic [CW-1:0]           lanes_done;
    logic [CW-1:0]           lanes_left;
    logic [T_DATA_WIDTH-1:0] base;

    assign sending    = (state_q == SEND);
    assign accept     = (state_q == IDLE) && start_i && (len_i != '0);
    assign hs         = sending && m_ready_i;
    assign lanes_done = CW'(beat_q) * CW'(KEEP_WIDTH);
    assign lanes_left = CW'(len_q) - lanes_done;
    assign last_beat  = (lanes_left <= CW'(KEEP_WIDTH));
    assign base       = seed_q + T_DATA_WIDTH'(lanes_done);

    always_comb begin
        state_d   = state_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        m_valid_o = 1'b0;
        m_last_o  = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: begin
                busy_o    = 1'b1;
                m_valid_o = 1'b1;
                m_last_o  = last_beat;
                if (hs && last_beat) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                len_q  <= len_i;
                seed_q <= seed_i;
                beat_q <= '0;
            end else if (hs) begin
                beat_q <= last_beat ? '0 : beat_q + LEN_WIDTH'(1);
            end
        end
    end

    // Per-lane keep/data; lanes past the frame end are masked and driven to 0.
    for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
        stream_frame_lane #(
            .T_DATA_WIDTH(T_DATA_WIDTH),
            .CW          (CW),
            .LANE        (i)
        ) u_lane (
            .active_i    (sending),
            .base_i      (base),
            .lanes_left_i(lanes_left),
            .keep_o      (m_keep_o[i]),
            .data_o      (m_data_o[i])
        );
    end
endmodule
